div_issue_ctrl: RTL and testbench

Operand issue and result capture stage placed directly in front of `div_top`. It accepts {A, B} operand pairs over a valid/ready stream and buffers them in a small FIFO. It launches one division at a time through `div_top`'s start/busy/valid/ov interface and returns {Q, ov} results in order over a second valid/ready stream. A watchdog and a saturating overflow counter are included.

---
 rtl/div_issue_if.sv | 43 ++++
 rtl/div_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_if.sv
// Operand stream, result stream and div_top launch/return signals of div_issue_ctrl.
// Streams op_* and res_*: a word transfers on a rising edge where valid and ready are both high;
// a producer holding valid keeps its payload stable until that edge and never waits for ready.
interface div_issue_if #(
  parameter int W = 10
);
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;

  logic         div_start;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_busy;
  logic         div_valid;
  logic [W-1:0] div_q;
  logic         div_ov;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_q;
  logic         res_ov;
  logic         res_to;

  modport master (
    input  op_valid, op_a, op_b,
    input  div_busy, div_valid, div_q, div_ov,
    input  res_ready,
    output op_ready,
    output div_start, div_a, div_b,
    output res_valid, res_q, res_ov, res_to
  );

  modport slave (
    output op_valid, op_a, op_b,
    output div_busy, div_valid, div_q, div_ov,
    output res_ready,
    input  op_ready,
    input  div_start, div_a, div_b,
    input  res_valid, res_q, res_ov, res_to
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Operand FIFO, single-flight launch FSM for div_top, result slot with timeout, and
// saturating overflow counter.
module div_issue_ctrl #(
  parameter int W       = 10,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  div_issue_if.master   bus,
  output logic [7:0]    ov_count,
  output logic [LW-1:0] fifo_level,
  output logic [1:0]    dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ARM    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [TW-1:0]  timer;

  logic push;
  logic pop;
  logic slot_free;
  logic done;
  logic expire;

  assign bus.op_ready  = (fifo_level < LW'(DEPTH));
  assign push          = bus.op_valid & bus.op_ready;
  // The slot counts as free when the consumer takes the held result on this same edge.
  assign slot_free     = ~bus.res_valid | bus.res_ready;
  assign bus.div_start = (state == S_LAUNCH);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.op_a, bus.op_b};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done       = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if ((fifo_level != '0) && slot_free) begin
          pop        = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: state_next = S_ARM;
      // Guard cycle: a valid still standing from the previous operation is ignored here.
      S_ARM:    state_next = S_WAIT;
      S_WAIT: begin
        if (bus.div_valid && !bus.div_busy) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (timer == TMAX) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state == S_ARM) begin
      timer <= '0;
    end else if (state == S_WAIT) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.div_a <= '0;
      bus.div_b <= '0;
    end else if (pop) begin
      bus.div_a <= mem[rd_ptr][2*W-1:W];
      bus.div_b <= mem[rd_ptr][W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_q     <= '0;
      bus.res_ov    <= 1'b0;
      bus.res_to    <= 1'b0;
      ov_count      <= '0;
    end else if (done) begin
      bus.res_valid <= 1'b1;
      bus.res_q     <= bus.div_q;
      bus.res_ov    <= bus.div_ov;
      bus.res_to    <= 1'b0;
      if (bus.div_ov && (ov_count != 8'hFF)) begin
        ov_count <= ov_count + 8'd1;
      end
    end else if (expire) begin
      bus.res_valid <= 1'b1;
      bus.res_q     <= '0;
      bus.res_ov    <= 1'b0;
      bus.res_to    <= 1'b1;
    end else if (bus.res_valid && bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a behavioural div_top stand-in, an operand driver, and a result
// monitor that checks against expected results queued when each operand pair is accepted.
module tb_div_issue_ctrl;
  localparam int W       = 10;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam logic [W-1:0] QMASK = 10'b1001100001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    ov_count;
  logic [LW-1:0] fifo_level;
  logic [1:0]    dbg_state;

  div_issue_if #(.W(W)) bus ();

  div_issue_ctrl #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .ov_count   (ov_count),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [W+1:0]   exp_q[$];     // {to, ov, q}
  logic [2*W-1:0] launch_q[$];  // {a, b} in acceptance order

  int stub_mode = 0;  // 0 normal, 1 force overflow, 2 never completes, 3 stale valid then never
  int lat_min = 1;
  int lat_max = 1;
  int rr_mode = 1;    // 0 hold res_ready low, 1 high, 2 random
  int stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result for an accepted pair: the divider stand-in returns a^b^QMASK with
  // overflow on a>b; a divider that never answers yields a timeout result.
  function automatic logic [W+1:0] expect_for(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] r;
    if (stub_mode >= 2) r = {1'b1, 1'b0, {W{1'b0}}};
    else r = {1'b0, (stub_mode == 1) ? 1'b1 : (a > b), a ^ b ^ QMASK};
    return r;
  endfunction

  // ---------------- div_top stand-in ----------------
  int stub_phase = 0;
  int stub_cnt = 0;
  int n_starts = 0;
  int start_cyc = 0;
  logic [W-1:0] pend_q;
  logic pend_ov;
  logic [2*W-1:0] exp_ab;

  always @(negedge clk) begin
    if (rst) begin
      bus.div_busy  = 1'b0;
      bus.div_valid = 1'b0;
      bus.div_q     = '0;
      bus.div_ov    = 1'b0;
      stub_phase    = 0;
      launch_q.delete();
    end else if (bus.div_start) begin
      n_starts++;
      start_cyc = cyc;
      check("launch_has_operands", (launch_q.size() != 0), 1);
      if (launch_q.size() != 0) begin
        exp_ab = launch_q.pop_front();
        check("div_a", bus.div_a, exp_ab[2*W-1:W]);
        check("div_b", bus.div_b, exp_ab[W-1:0]);
      end
      if (stub_mode == 2) begin
        bus.div_busy = 1'b1; bus.div_valid = 1'b0; stub_phase = 2;
      end else if (stub_mode == 3) begin
        stub_phase = 3; stub_cnt = 1;
      end else begin
        bus.div_busy = 1'b1; bus.div_valid = 1'b0;
        stub_cnt = $urandom_range(lat_max, lat_min);
        pend_q = bus.div_a ^ bus.div_b ^ QMASK;
        pend_ov = (stub_mode == 1) ? 1'b1 : (bus.div_a > bus.div_b);
        stub_phase = 1;
      end
    end else if (stub_phase == 1) begin
      if (stub_cnt > 1) stub_cnt--;
      else begin
        bus.div_busy = 1'b0; bus.div_valid = 1'b1;
        bus.div_q = pend_q; bus.div_ov = pend_ov;
        stub_phase = 0;
      end
    end else if (stub_phase == 3) begin
      if (stub_cnt > 0) stub_cnt--;
      else begin
        bus.div_valid = 1'b0; bus.div_busy = 1'b1; stub_phase = 2;
      end
    end
  end

  // ---------------- consumer ready ----------------
  always begin
    @(posedge clk);
    #1;
    if (rr_mode == 2) bus.res_ready = ($urandom_range(3, 0) != 0);
    else bus.res_ready = (rr_mode == 1);
  end

  // ---------------- result monitor / scoreboard ----------------
  logic prev_rv = 1'b0;
  int rise_cyc = 0;
  int ov_seen = 0;
  int n_results = 0;
  logic [W+1:0] exp_r;

  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      ov_seen = 0;
      exp_q.delete();
    end else begin
      check("op_ready_vs_level", bus.op_ready, (fifo_level < LW'(DEPTH)));
      if (bus.res_valid && !prev_rv) rise_cyc = cyc;
      prev_rv = bus.res_valid;
      if (bus.res_valid && bus.res_ready) begin
        check("result_was_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_r = exp_q.pop_front();
          check("res_q", bus.res_q, exp_r[W-1:0]);
          check("res_ov", bus.res_ov, exp_r[W]);
          check("res_to", bus.res_to, exp_r[W+1]);
          if (exp_r[W] && !exp_r[W+1]) ov_seen++;
          check("ov_count", ov_count, (ov_seen > 255) ? 255 : ov_seen);
          n_results++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int guard = 0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    while (!bus.op_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
      stalls++;
    end
    check("push_accepted", bus.op_ready, 1);
    if (bus.op_ready) begin
      @(posedge clk);
      launch_q.push_back({a, b});
      exp_q.push_back(expect_for(a, b));
      #1;
    end
    bus.op_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int g = 0;
    while (exp_q.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("drain_complete", exp_q.size(), 0);
  endtask

  task automatic check_reset_values();
    check("rst_op_ready", bus.op_ready, 1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_q", bus.res_q, 0);
    check("rst_res_ov", bus.res_ov, 0);
    check("rst_res_to", bus.res_to, 0);
    check("rst_ov_count", ov_count, 0);
    check("rst_div_start", bus.div_start, 0);
    check("rst_div_a", bus.div_a, 0);
    check("rst_div_b", bus.div_b, 0);
    check("rst_state", dbg_state, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    launch_q.delete();
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int max_level;
    int s0;
    int g;
    logic [W-1:0] held_q;
    logic flag_start;
    logic flag_change;
    logic flag_quiet;

    bus.op_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    do_reset();

    // single operation, launch timing and completion latency
    stub_mode = 0; lat_min = 18; lat_max = 18;
    push_op(10'b0010101000, 10'b1110011100);
    @(negedge clk);
    check("start_not_at_n1", bus.div_start, 0);
    @(negedge clk);
    check("start_at_n2", bus.div_start, 1);
    check("single_div_a", bus.div_a, 10'b0010101000);
    check("single_div_b", bus.div_b, 10'b1110011100);
    drain(200);
    check("single_latency", rise_cyc - start_cyc, 19);

    // FIFO fill with a slow divider
    lat_min = 25; lat_max = 25;
    max_level = 0;
    stalls = 0;
    for (int i = 0; i < 6; i++) begin
      push_op(W'($urandom_range(1023, 0)), W'($urandom_range(1023, 0)));
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    check("fill_max_level", max_level, DEPTH);
    check("fill_stalled", (stalls > 0), 1);
    drain(1000);

    // backpressure on the result slot
    lat_min = 5; lat_max = 5;
    @(negedge clk);
    rr_mode = 0;
    push_op(10'd700, 10'd33);
    push_op(10'd12, 10'd900);
    g = 0;
    while (!bus.res_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("bp_first_result", bus.res_valid, 1);
    held_q = bus.res_q;
    s0 = n_starts;
    flag_change = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.res_q !== held_q || !bus.res_valid) flag_change = 1'b1;
    end
    flag_start = (n_starts != s0);
    check("bp_no_second_start", flag_start, 0);
    check("bp_result_stable", flag_change, 0);
    rr_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_start_after_handshake", bus.div_start, 1);
    drain(200);

    // overflow counting and saturation
    do_reset();
    stub_mode = 1; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3; i++) push_op(W'($urandom_range(1023, 0)), W'($urandom_range(1023, 0)));
    drain(200);
    check("ov_count_3", ov_count, 3);
    for (int i = 0; i < 254; i++) push_op(W'($urandom_range(1023, 0)), W'($urandom_range(1023, 0)));
    drain(5000);
    check("ov_count_saturated", ov_count, 255);

    // timeout with a silent divider
    stub_mode = 2;
    push_op(10'd5, 10'd3);
    drain(200);
    check("timeout_latency", rise_cyc - start_cyc, TIMEOUT + 3);
    check("timeout_no_ov_count", ov_count, 255);

    // stale valid across LAUNCH/ARM must not complete the next operation
    stub_mode = 0; lat_min = 3; lat_max = 3;
    push_op(10'd100, 10'd200);
    drain(200);
    stub_mode = 3;
    push_op(10'd300, 10'd7);
    drain(200);
    check("stale_timeout_latency", rise_cyc - start_cyc, TIMEOUT + 3);

    // reset while an operation waits, two more queued
    stub_mode = 0; lat_min = 25; lat_max = 25;
    s0 = n_starts;
    push_op(10'd1, 10'd2);
    push_op(10'd3, 10'd4);
    push_op(10'd5, 10'd6);
    g = 0;
    while (n_starts == s0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("in_wait_before_reset", dbg_state, 3);
    check("queued_before_reset", (fifo_level != 0), 1);
    do_reset();
    flag_quiet = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.res_valid || bus.div_start) flag_quiet = 1'b1;
    end
    check("quiet_after_reset", flag_quiet, 0);

    // randomized traffic with random backpressure
    stub_mode = 0; lat_min = 1; lat_max = 25;
    @(negedge clk);
    rr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      push_op(W'($urandom_range(1023, 0)), W'($urandom_range(1023, 0)));
    end
    drain(5000);
    @(negedge clk);
    rr_mode = 1;
    repeat (5) @(negedge clk);
    check("results_seen", (n_results > 300), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
